// File: rtl/regfile_rename_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_rename_mp
// Purpose  : Architectural register file with per-register rename tags,
//            NUM_RD bypassed read ports, NUM_CDB broadcast channels and flush.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_rename_mp #(
    parameter int DATA_W   = 32,
    parameter int REG_NUM  = 32,
    parameter int NAME_W   = 5,
    parameter int TAG_W    = 4,
    parameter int TAG_FREE = 0,
    parameter int NUM_RD   = 4,
    parameter int NUM_CDB  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [NUM_CDB-1:0]         cdb_valid,
    input  logic [NUM_CDB*NAME_W-1:0]  cdb_name,
    input  logic [NUM_CDB*TAG_W-1:0]   cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0]  cdb_data,
    input  logic                       disp_en,
    input  logic [NAME_W-1:0]          disp_name,
    input  logic [TAG_W-1:0]           disp_tag,
    input  logic [NUM_RD*NAME_W-1:0]   rd_name,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD*TAG_W-1:0]    rd_tag,
    output logic [NAME_W:0]            busy_cnt
);

    localparam logic [TAG_W-1:0] c_free = TAG_W'(TAG_FREE);

    logic [DATA_W-1:0] r_data [REG_NUM];
    logic [TAG_W-1:0]  r_tag  [REG_NUM];

    // Register 0 is never written after reset, so it stays 0 / free.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                r_data[i] <= '0;
                r_tag[i]  <= c_free;
            end
        end else if (flush) begin
            for (int i = 0; i < REG_NUM; i++) begin
                r_tag[i] <= c_free;
            end
        end else begin
            for (int i = 1; i < REG_NUM; i++) begin
                for (int c = 0; c < NUM_CDB; c++) begin
                    if (cdb_valid[c] &&
                        cdb_name[c*NAME_W +: NAME_W] == NAME_W'(i) &&
                        cdb_tag[c*TAG_W +: TAG_W] == r_tag[i] &&
                        cdb_tag[c*TAG_W +: TAG_W] != c_free) begin
                        r_data[i] <= cdb_data[c*DATA_W +: DATA_W];
                        r_tag[i]  <= c_free;
                    end
                end
                // Later assignment: a same-cycle rename overrides the CDB tag clear.
                if (disp_en && disp_name == NAME_W'(i)) begin
                    r_tag[i] <= disp_tag;
                end
            end
        end
    end

    logic [NAME_W-1:0] w_name;
    logic [DATA_W-1:0] w_data;
    logic [TAG_W-1:0]  w_tag;

    always_comb begin
        rd_data = '0;
        rd_tag  = {NUM_RD{c_free}};
        w_name  = '0;
        w_data  = '0;
        w_tag   = c_free;
        for (int p = 0; p < NUM_RD; p++) begin
            w_name = rd_name[p*NAME_W +: NAME_W];
            w_data = '0;
            w_tag  = c_free;
            if (w_name != '0 && int'(w_name) < REG_NUM) begin
                w_data = r_data[w_name];
                w_tag  = r_tag[w_name];
                for (int c = 0; c < NUM_CDB; c++) begin
                    if (cdb_valid[c] &&
                        cdb_name[c*NAME_W +: NAME_W] == w_name &&
                        cdb_tag[c*TAG_W +: TAG_W] == r_tag[w_name] &&
                        cdb_tag[c*TAG_W +: TAG_W] != c_free) begin
                        w_data = cdb_data[c*DATA_W +: DATA_W];
                        w_tag  = c_free;
                    end
                end
            end
            if (!rst) begin
                rd_data[p*DATA_W +: DATA_W] = w_data;
                rd_tag[p*TAG_W +: TAG_W]    = w_tag;
            end
        end
    end

    logic [NAME_W:0] w_busy;

    always_comb begin
        w_busy = '0;
        for (int i = 1; i < REG_NUM; i++) begin
            w_busy = w_busy + (NAME_W+1)'(r_tag[i] != c_free);
        end
        busy_cnt = rst ? '0 : w_busy;
    end

endmodule
`default_nettype wire

// File: doc/regfile_rename_mp.md
Name: regfile_rename_mp

Overview:
- Parametrised successor to the single-CDB, two-read-port architectural register file with rename tags.
- Holds architectural data plus a producer tag per register. Serves NUM_RD combinational source reads with same-cycle CDB bypass.
- Accepts NUM_CDB broadcast channels and one dispatch rename per cycle. Supports a global flush that frees all tags.
- Sits between decoder/dispatcher and the reservation stations.

Parameters:
- DATA_W, 32, register data width
- REG_NUM, 32, number of architectural registers; register 0 is hardwired zero
- NAME_W, 5, register name width; clog2(REG_NUM)
- TAG_W, 4, rename tag width
- TAG_FREE, 0, tag encoding meaning "value valid, no pending producer"
- NUM_RD, 4, number of read ports
- NUM_CDB, 2, number of CDB broadcast channels

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  mispredict flush: free all tags
- cdb_valid  in  NUM_CDB  per-channel broadcast valid
- cdb_name  in  NUM_CDB*NAME_W  destination register per channel (channel c at bits [c*NAME_W +: NAME_W])
- cdb_tag  in  NUM_CDB*TAG_W  producer tag per channel
- cdb_data  in  NUM_CDB*DATA_W  result per channel
- disp_en  in  1  dispatch rename enable
- disp_name  in  NAME_W  register being renamed
- disp_tag  in  TAG_W  new producer tag
- rd_name  in  NUM_RD*NAME_W  read port names
- rd_data  out  NUM_RD*DATA_W  read data
- rd_tag  out  NUM_RD*TAG_W  read tag (TAG_FREE means rd_data is valid)
- busy_cnt  out  NAME_W+1  number of registers with tag != TAG_FREE

Behaviour:
- Reset (rst high at a clk edge): all data <= 0, all tags <= TAG_FREE. While rst is high: all rd_data = 0, all rd_tag = TAG_FREE, busy_cnt = 0. Reset dominates flush, CDB and dispatch.
- Register 0: reads always return data 0 / TAG_FREE. CDB and dispatch writes to name 0 are ignored.
- CDB commit, per clock edge, for each channel c with cdb_valid[c] and cdb_name != 0:
  - If tag[name] == cdb_tag[c] and cdb_tag[c] != TAG_FREE: data[name] <= cdb_data[c] and tag[name] <= TAG_FREE.
  - Tag mismatch: no write. Stale producer results are dropped, so the architectural data is not corrupted.
- Tags are unique among in-flight ops, so at most one channel matches a given register per cycle. Several channels naming the same register with different tags: only the matching channel writes.
- Dispatch: disp_en with disp_name != 0 sets tag[disp_name] <= disp_tag. If the same cycle's CDB clears that register, dispatch wins: the tag ends as disp_tag, while data still takes the CDB value.
- Flush (rst low): all tags <= TAG_FREE, data untouched. CDB commits and dispatch in the flush cycle are ignored.
- Read ports are combinational, zero latency, and show pre-edge state, i.e. before this cycle's dispatch rename. An instruction with rs == rd therefore sees the old producer.
- Bypass: if the current tag of rd_name matches a valid, non-free cdb_tag on a channel whose cdb_name equals rd_name, output that cdb_data and TAG_FREE. Otherwise output the stored data/tag. Bypass is also active in a flush cycle.
- busy_cnt: combinational popcount of non-free tags over registers 1..REG_NUM-1. It reflects registered state only.
- Latency: a write is visible through storage one cycle after the edge. A CDB result is visible the same cycle via bypass.

Test Plan:
- Reset, then read all ports of names 0, 5, 31 -> data 0, tag TAG_FREE, busy_cnt 0.
- Dispatch r5 tag 3; next cycle CDB ch1 {r5, tag 3, 0xDEADBEEF}:
  - In the CDB cycle, reading r5 -> 0xDEADBEEF / TAG_FREE via bypass.
  - Following cycle -> the same values from storage; busy_cnt back to 0.
- Dispatch r7 tag 2, then r7 tag 6:
  - CDB {r7, tag 2, 0x11} -> r7 keeps old data, tag 6.
  - CDB {r7, tag 6, 0x22} -> 0x22 / TAG_FREE.
- Same cycle: CDB {r9, tag 4, 0x55} clears r9 while dispatch renames r9 to tag 8 -> next cycle r9 data 0x55, tag 8.
- Rename r1..r10 (busy_cnt 10), then pulse flush together with CDB {r3, matching tag, 0x77} and dispatch r12 -> all tags TAG_FREE, r3 data unchanged, r12 tag TAG_FREE, busy_cnt 0.
- Writes to r0 via CDB and dispatch -> r0 reads 0 / TAG_FREE. Assert rst mid-rename -> all state cleared next cycle.
